johnson_step_ctrl: RTL and testbench

Command-driven sequencer for the team's 4-bit Johnson counter datapath. It accepts a step command over a valid/ready handshake and advances the Johnson code the requested number of steps, forward or reverse. Steps are paced by a programmable prescaler. It reports completion or abort with a one-cycle done pulse. It sits between a host/register block and any phase-driven load, such as a stepper-phase or LED-chaser output.

---
 rtl/johnson_step_ctrl.sv | 150 +++++++++++++++
 tb/tb_johnson_step_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_step_ctrl.sv
// Command-driven sequencer for a Johnson counter: accepts a step command and
// advances the code forward or reverse, with each step paced by a prescaler.
module johnson_step_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0] cmd_rate,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_taken
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_dir;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_rate;
  logic [CNT_W-1:0] r_tick;
  logic [CNT_W-1:0] r_steps_taken;
  logic [WIDTH-1:0] r_data;
  logic             r_aborted;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_abort_run;
  logic [WIDTH-1:0] w_data_fwd;
  logic [WIDTH-1:0] w_data_rev;
  logic             w_cmd_ready_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // Abort outranks a pending step on the same edge
  assign w_accept    = cmd_valid && r_cmd_ready;
  assign w_abort_run = (r_state == S_RUN) && abort;
  assign w_step      = (r_state == S_RUN) && !abort && (r_tick == '0);
  assign w_last      = w_step && (r_remaining == CNT_W'(1));

  assign w_data_fwd  = {r_data[WIDTH-2:0], ~r_data[WIDTH-1]};
  assign w_data_rev  = {~r_data[0], r_data[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (cmd_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort_run || w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags are registered
  always_comb begin
    w_cmd_ready_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    case (w_state_nxt)
      S_IDLE:  w_cmd_ready_nxt = 1'b1;
      S_RUN:   w_busy_nxt      = 1'b1;
      S_DONE:  w_done_nxt      = 1'b1;
      default: w_cmd_ready_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Command latch, prescaler, progress counters and Johnson register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir         <= 1'b0;
      r_remaining   <= '0;
      r_rate        <= '0;
      r_tick        <= '0;
      r_steps_taken <= '0;
      r_data        <= '0;
      r_aborted     <= 1'b0;
    end else if (w_accept) begin
      r_dir         <= cmd_dir;
      r_remaining   <= cmd_steps;
      r_rate        <= cmd_rate;
      r_tick        <= cmd_rate;
      r_steps_taken <= '0;
      r_aborted     <= 1'b0;
    end else if (w_abort_run) begin
      r_aborted     <= 1'b1;
    end else if (w_step) begin
      r_data        <= r_dir ? w_data_rev : w_data_fwd;
      r_tick        <= r_rate;
      r_remaining   <= r_remaining - CNT_W'(1);
      r_steps_taken <= r_steps_taken + CNT_W'(1);
    end else if (r_state == S_RUN) begin
      r_tick        <= r_tick - CNT_W'(1);
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign steps_taken = r_steps_taken;
  assign data_out    = r_data;

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Directed-vector bench for johnson_step_ctrl with hand-computed expectations.
module tb_johnson_step_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [CNT_W-1:0] cmd_rate;
  logic             abort;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_taken;

  int n_vec;
  int n_err;

  johnson_step_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cmd_steps   (cmd_steps),
    .cmd_rate    (cmd_rate),
    .abort       (abort),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .steps_taken (steps_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic dir, input int steps, input int rate);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = CNT_W'(steps);
    cmd_rate  = CNT_W'(rate);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [WIDTH-1:0] fwd8 [8];
  logic [WIDTH-1:0] rev3 [3];
  logic [WIDTH-1:0] fwd3 [3];
  int acc_cnt;
  int done_cnt;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_steps = '0;
    cmd_rate = '0;
    abort = 1'b0;
    fwd8 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    rev3 = '{4'b1000, 4'b1100, 4'b1110};
    fwd3 = '{4'b1100, 4'b1000, 4'b0000};

    do_reset();
    check_vec("rst_data", 32'(data_out), 32'h0);
    check_vec("rst_ready", 32'(cmd_ready), 32'h1);
    check_vec("rst_busy", 32'(busy), 32'h0);
    check_vec("rst_done", 32'(done), 32'h0);
    check_vec("rst_aborted", 32'(aborted), 32'h0);
    check_vec("rst_steps", 32'(steps_taken), 32'h0);

    // abort while idle has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_vec("idle_abort_ready", 32'(cmd_ready), 32'h1);
    check_vec("idle_abort_aborted", 32'(aborted), 32'h0);

    // forward 8 steps, rate 0
    issue(1'b0, 8, 0);
    check_vec("f8_busy", 32'(busy), 32'h1);
    check_vec("f8_ready", 32'(cmd_ready), 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_vec($sformatf("f8_data%0d", k), 32'(data_out), 32'(fwd8[k]));
    end
    check_vec("f8_done", 32'(done), 32'h1);
    check_vec("f8_busy_end", 32'(busy), 32'h0);
    check_vec("f8_steps", 32'(steps_taken), 32'd8);
    check_vec("f8_aborted", 32'(aborted), 32'h0);
    tick();
    check_vec("f8_done_clr", 32'(done), 32'h0);
    check_vec("f8_ready_back", 32'(cmd_ready), 32'h1);

    // reverse 3 then forward 3
    issue(1'b1, 3, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_vec($sformatf("r3_data%0d", k), 32'(data_out), 32'(rev3[k]));
    end
    tick();
    issue(1'b0, 3, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_vec($sformatf("f3_data%0d", k), 32'(data_out), 32'(fwd3[k]));
    end
    tick();

    // forward 2 at rate 3: steps land at E4 and E8
    issue(1'b0, 2, 3);
    check_vec("p_busy0", 32'(busy), 32'h1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      check_vec($sformatf("p_data%0d", c), 32'(data_out),
                (c < 4) ? 32'h0 : ((c < 8) ? 32'h1 : 32'h3));
      check_vec($sformatf("p_busy%0d", c), 32'(busy), (c < 8) ? 32'h1 : 32'h0);
      check_vec($sformatf("p_done%0d", c), 32'(done), (c == 8) ? 32'h1 : 32'h0);
    end
    tick();
    check_vec("p_ready_back", 32'(cmd_ready), 32'h1);

    // abort after two steps of a 10-step rate-1 command
    do_reset();
    issue(1'b0, 10, 1);
    tick();
    tick();
    check_vec("ab_data_e2", 32'(data_out), 32'h1);
    tick();
    tick();
    check_vec("ab_data_e4", 32'(data_out), 32'h3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_vec("ab_done", 32'(done), 32'h1);
    check_vec("ab_aborted", 32'(aborted), 32'h1);
    check_vec("ab_steps", 32'(steps_taken), 32'd2);
    check_vec("ab_data", 32'(data_out), 32'h3);
    check_vec("ab_busy", 32'(busy), 32'h0);
    tick();
    check_vec("ab_done_clr", 32'(done), 32'h0);
    check_vec("ab_aborted_hold", 32'(aborted), 32'h1);
    check_vec("ab_ready_back", 32'(cmd_ready), 32'h1);

    // zero-step command: done next cycle, data unchanged
    issue(1'b0, 0, 5);
    check_vec("z_done", 32'(done), 32'h1);
    check_vec("z_data", 32'(data_out), 32'h3);
    check_vec("z_steps", 32'(steps_taken), 32'h0);
    check_vec("z_aborted", 32'(aborted), 32'h0);
    check_vec("z_busy", 32'(busy), 32'h0);
    tick();
    check_vec("z_ready_back", 32'(cmd_ready), 32'h1);

    // cmd_valid held high with steps=1: accept every third edge
    acc_cnt  = 0;
    done_cnt = 0;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_steps = CNT_W'(1);
    cmd_rate  = CNT_W'(0);
    for (int i = 0; i < 9; i++) begin
      if (cmd_ready) acc_cnt++;
      tick();
      if (done) done_cnt++;
    end
    cmd_valid = 1'b0;
    check_vec("hv_accepts", 32'(acc_cnt), 32'd3);
    check_vec("hv_dones", 32'(done_cnt), 32'd3);
    check_vec("hv_data", 32'(data_out), 32'hE);
    check_vec("hv_ready", 32'(cmd_ready), 32'h1);

    // reset in the middle of a 6-step command
    issue(1'b0, 6, 0);
    tick();
    tick();
    check_vec("mr_data_pre", 32'(data_out), 32'h8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_vec("mr_data", 32'(data_out), 32'h0);
    check_vec("mr_busy", 32'(busy), 32'h0);
    check_vec("mr_done", 32'(done), 32'h0);
    check_vec("mr_ready", 32'(cmd_ready), 32'h1);
    check_vec("mr_steps", 32'(steps_taken), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec($sformatf("mr_nodone%0d", i), 32'(done), 32'h0);
      check_vec($sformatf("mr_hold%0d", i), 32'(data_out), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
